cpu_multiply_control: RTL and testbench

CPU_MULTIPLY_CONTROL -- requirements
Module: cpu_multiply_control

---
 rtl/cpu_multiply_control.sv | 139 +++++++++++++
 tb/tb_cpu_multiply_control.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_multiply_control.sv
// Sequencer between the integer pipeline and an external 32x32 multiplier: launches the
// multiply, then fixes up the high word for MULHSU. Optional one-entry product cache: CPU_MUL_RESULT_CACHE_EN.
module cpu_multiply_control (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic [1:0]  i_funct,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    output logic        o_busy,
    output logic        o_ready,
    output logic [31:0] o_rd,
    output logic        o_mul_latch,
    output logic        o_mul_signed,
    output logic [31:0] o_mul_op1,
    output logic [31:0] o_mul_op2,
    input  logic        i_mul_ready,
    input  logic [63:0] i_mul_result
);

    typedef enum logic [1:0] {IDLE, WAIT, FIXUP, DONE} state_t;

    localparam logic [1:0] FUNCT_MUL    = 2'b00;
    localparam logic [1:0] FUNCT_MULH   = 2'b01;
    localparam logic [1:0] FUNCT_MULHSU = 2'b10;
    localparam logic [1:0] FUNCT_MULHU  = 2'b11;

    state_t      state_reg, state_next;
    logic [2:0]  drain_reg;
    logic [1:0]  funct_reg;
    logic [31:0] op1_reg, op2_reg;
    logic [63:0] prod_reg;
    logic [31:0] rd_reg, rd_next;
    logic        mul_latch_reg;
    logic        mul_signed_reg;
    logic        accept;
    logic        cache_hit;
    logic [63:0] hit_prod;

`ifdef CPU_MUL_RESULT_CACHE_EN
    logic        cache_valid_reg;
    logic [31:0] cache_op1_reg, cache_op2_reg;
    logic        cache_signed_reg;
    logic [63:0] cache_prod_reg;

    // Signed class is part of the key: MUL/MULHSU/MULHU share the unsigned product.
    assign cache_hit = cache_valid_reg && (cache_op1_reg == i_op1) && (cache_op2_reg == i_op2)
                       && (cache_signed_reg == (i_funct == FUNCT_MULH));
    assign hit_prod  = cache_prod_reg;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cache_valid_reg  <= 1'b0;
            cache_op1_reg    <= '0;
            cache_op2_reg    <= '0;
            cache_signed_reg <= 1'b0;
            cache_prod_reg   <= '0;
        end else if (state_reg == WAIT && i_mul_ready) begin
            cache_valid_reg  <= 1'b1;
            cache_op1_reg    <= op1_reg;
            cache_op2_reg    <= op2_reg;
            cache_signed_reg <= mul_signed_reg;
            cache_prod_reg   <= i_mul_result;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_prod  = '0;
`endif

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_request && drain_reg == 3'd0) begin
                    accept     = 1'b1;
                    state_next = cache_hit ? FIXUP : WAIT;
                end
            end
            WAIT:    if (i_mul_ready) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // MULHSU is issued unsigned; subtracting op2 when op1 is negative restores the signed-op1 high word.
    always_comb begin
        rd_next = prod_reg[63:32];
        case (funct_reg)
            FUNCT_MUL:    rd_next = prod_reg[31:0];
            FUNCT_MULH:   rd_next = prod_reg[63:32];
            FUNCT_MULHSU: rd_next = prod_reg[63:32] - (op1_reg[31] ? op2_reg : 32'd0);
            FUNCT_MULHU:  rd_next = prod_reg[63:32];
            default:      rd_next = prod_reg[63:32];
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg      <= IDLE;
            drain_reg      <= 3'd5;
            funct_reg      <= '0;
            op1_reg        <= '0;
            op2_reg        <= '0;
            prod_reg       <= '0;
            rd_reg         <= '0;
            mul_latch_reg  <= 1'b0;
            mul_signed_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mul_latch_reg <= (state_next == WAIT);
            if (drain_reg != 3'd0)
                drain_reg <= drain_reg - 3'd1;
            if (accept) begin
                funct_reg      <= i_funct;
                op1_reg        <= i_op1;
                op2_reg        <= i_op2;
                mul_signed_reg <= (i_funct == FUNCT_MULH);
            end
            if (state_reg == WAIT && i_mul_ready)
                prod_reg <= i_mul_result;
            else if (accept && cache_hit)
                prod_reg <= hit_prod;
            if (state_reg == FIXUP)
                rd_reg <= rd_next;
        end
    end

    assign o_busy       = (state_reg != IDLE) || (drain_reg != 3'd0);
    assign o_ready      = (state_reg == DONE);
    assign o_rd         = rd_reg;
    assign o_mul_latch  = mul_latch_reg;
    assign o_mul_signed = mul_signed_reg;
    assign o_mul_op1    = op1_reg;
    assign o_mul_op2    = op2_reg;

endmodule

// File: tb/tb_cpu_multiply_control.sv
// Directed bench for cpu_multiply_control with a 4-cycle pipelined multiplier model.
module tb_cpu_multiply_control;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_request;
    logic [1:0]  i_funct;
    logic [31:0] i_op1, i_op2;
    logic        o_busy, o_ready;
    logic [31:0] o_rd;
    logic        o_mul_latch, o_mul_signed;
    logic [31:0] o_mul_op1, o_mul_op2;
    logic        i_mul_ready;
    logic [63:0] i_mul_result;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

`ifdef CPU_MUL_RESULT_CACHE_EN
    localparam int HIT_LAT = 2;
`else
    localparam int HIT_LAT = 7;
`endif

    cpu_multiply_control dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_request    (i_request),
        .i_funct      (i_funct),
        .i_op1        (i_op1),
        .i_op2        (i_op2),
        .o_busy       (o_busy),
        .o_ready      (o_ready),
        .o_rd         (o_rd),
        .o_mul_latch  (o_mul_latch),
        .o_mul_signed (o_mul_signed),
        .o_mul_op1    (o_mul_op1),
        .o_mul_op2    (o_mul_op2),
        .i_mul_ready  (i_mul_ready),
        .i_mul_result (i_mul_result)
    );

    always #5 i_clock = ~i_clock;
    always @(posedge i_clock) cyc <= cyc + 1;

    // Multiplier model: product of operands at the latch rising edge, ready 4 cycles later.
    // Not reset by i_reset, so an aborted operation still produces its late pulse.
    logic        latch_prev = 1'b0;
    logic        rdy_pipe [4] = '{default: 1'b0};
    logic [63:0] prod_pipe [4] = '{default: 64'd0};
    logic [63:0] ext1, ext2;

    always_comb begin
        ext1 = o_mul_signed ? {{32{o_mul_op1[31]}}, o_mul_op1} : {32'd0, o_mul_op1};
        ext2 = o_mul_signed ? {{32{o_mul_op2[31]}}, o_mul_op2} : {32'd0, o_mul_op2};
    end

    always @(posedge i_clock) begin
        latch_prev   <= o_mul_latch;
        rdy_pipe[0]  <= o_mul_latch && !latch_prev;
        prod_pipe[0] <= ext1 * ext2;
        for (int k = 1; k < 4; k++) begin
            rdy_pipe[k]  <= rdy_pipe[k-1];
            prod_pipe[k] <= prod_pipe[k-1];
        end
    end

    assign i_mul_ready  = rdy_pipe[3];
    assign i_mul_result = rdy_pipe[3] ? prod_pipe[3] : 64'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; issues one request and tracks it to o_ready.
    task automatic do_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_rd, input int exp_lat,
                         input logic exp_sgn, input logic exp_latch);
        int  t0;
        int  lat;
        bit  seen_latch;
        bit  done;
        t0 = cyc; lat = -1; seen_latch = 0; done = 0;
        i_funct = f; i_op1 = a; i_op2 = b; i_request = 1'b1;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge i_clock);
            i_request = 1'b0;
            if (o_mul_latch && !seen_latch) begin
                seen_latch = 1;
                check({tag, "_signed"}, {63'd0, o_mul_signed}, {63'd0, exp_sgn});
            end
            if (o_ready) begin
                done = 1;
                lat = cyc - t0;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_rd"}, {32'd0, o_rd}, {32'd0, exp_rd});
        check({tag, "_latch_used"}, {63'd0, seen_latch}, {63'd0, exp_latch});
        $display("op %s funct=%0d a=0x%08h b=0x%08h rd=0x%08h latency=%0d", tag, f, a, b, o_rd, lat);
        @(negedge i_clock);
        check({tag, "_ready_pulse"}, {63'd0, o_ready}, 64'd0);
        check({tag, "_rd_held"}, {32'd0, o_rd}, {32'd0, exp_rd});
    endtask

    initial begin : main
        logic [63:0] p;
        int t0, r0, readies, first_t, second_t, low_run, min_low;
        bit had_high;

        i_reset = 1'b1; i_request = 1'b0; i_funct = 2'b00; i_op1 = '0; i_op2 = '0;
        repeat (3) @(negedge i_clock);
        check("reset_busy", {63'd0, o_busy}, 64'd1);
        check("reset_ready", {63'd0, o_ready}, 64'd0);
        check("reset_rd", {32'd0, o_rd}, 64'd0);
        check("reset_latch", {63'd0, o_mul_latch}, 64'd0);
        check("reset_signed", {63'd0, o_mul_signed}, 64'd0);
        check("reset_op1", {32'd0, o_mul_op1}, 64'd0);
        i_reset = 1'b0;
        repeat (6) @(negedge i_clock);
        check("drain_done_busy", {63'd0, o_busy}, 64'd0);

        do_op("mul_ff_2",     2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 7, 1'b0, 1'b1);
        do_op("mulh_min_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 7, 1'b1, 1'b1);
        do_op("mulhu_8_8",    2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 7, 1'b0, 1'b1);
        do_op("mulh_m1_1",    2'b01, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 7, 1'b1, 1'b1);
        do_op("mulhsu_m1_ff", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 7, 1'b0, 1'b1);
        do_op("mulhsu_7f_2",  2'b10, 32'h7FFFFFFF, 32'h00000002, 32'h00000000, 7, 1'b0, 1'b1);

        // Product cache: same operands and unsigned class, second op can skip the multiplier.
        p = 64'h12345678;
        p = p * 64'h9ABCDEF0;
        do_op("cache_mulhu", 2'b11, 32'h12345678, 32'h9ABCDEF0, p[63:32], 7, 1'b0, 1'b1);
        do_op("cache_mul",   2'b00, 32'h12345678, 32'h9ABCDEF0, 32'h242D2080, HIT_LAT, 1'b0,
              (HIT_LAT == 7));

        // Back-to-back with i_request held high throughout both operations.
        i_funct = 2'b00; i_op1 = 32'd5; i_op2 = 32'd7; i_request = 1'b1;
        t0 = cyc; readies = 0; first_t = -1; second_t = -1;
        low_run = 0; min_low = 99; had_high = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clock);
            if (o_mul_latch) begin
                if (had_high && low_run > 0 && low_run < min_low) min_low = low_run;
                had_high = 1; low_run = 0;
            end else begin
                low_run++;
            end
            if (first_t >= 0 && cyc == first_t + 2) i_request = 1'b0;
            if (o_ready) begin
                readies++;
                if (readies == 1) begin
                    first_t = cyc;
                    check("b2b_first_rd", {32'd0, o_rd}, 64'h23);
                    i_op1 = 32'd9; i_op2 = 32'd9;
                end else if (readies == 2) begin
                    second_t = cyc;
                    check("b2b_second_rd", {32'd0, o_rd}, 64'h51);
                end
            end
        end
        i_request = 1'b0;
        check("b2b_ready_count", 64'(readies), 64'd2);
        check("b2b_first_latency", 64'(first_t - t0), 64'd7);
        check("b2b_second_latency", 64'(second_t - first_t), 64'd8);
        check("b2b_latch_low_gap_ok", {63'd0, (min_low >= 2 && min_low != 99)}, 64'd1);
        $display("op b2b readies=%0d first=%0d second=%0d min_latch_low=%0d",
                 readies, first_t - t0, second_t - first_t, min_low);

        // Abort mid-WAIT with reset, then request immediately; the stale pulse lands in drain.
        i_funct = 2'b00; i_op1 = 32'd3; i_op2 = 32'd5; i_request = 1'b1;
        @(negedge i_clock);
        i_request = 1'b0;
        @(negedge i_clock);
        i_reset = 1'b1;
        @(negedge i_clock);
        check("abort_ready", {63'd0, o_ready}, 64'd0);
        check("abort_rd_cleared", {32'd0, o_rd}, 64'd0);
        check("abort_latch", {63'd0, o_mul_latch}, 64'd0);
        check("abort_busy", {63'd0, o_busy}, 64'd1);
        i_reset = 1'b0;
        i_funct = 2'b00; i_op1 = 32'h11; i_op2 = 32'h3; i_request = 1'b1;
        r0 = cyc; readies = 0; first_t = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge i_clock);
            if (k == 0) check("drain_busy", {63'd0, o_busy}, 64'd1);
            if (o_ready) begin
                readies++;
                if (readies == 1) begin
                    first_t = cyc;
                    check("abort_new_rd", {32'd0, o_rd}, 64'h33);
                end
            end
            if (first_t >= 0) i_request = 1'b0;
        end
        i_request = 1'b0;
        check("abort_ready_count", 64'(readies), 64'd1);
        check("abort_new_latency", 64'(first_t - r0), 64'd12);
        $display("op abort_then_mul readies=%0d latency_from_release=%0d", readies, first_t - r0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
